shift_seq_ctrl: RTL and testbench

Sequencing controller for the team's N-bit universal shift register, which takes ctrl 0=hold, 1=right shift, 2=left shift, 3=parallel load. It turns the register into a serializer (TX: parallel word in, serial bits out) or a deserializer (RX: serial bits in, parallel word out). It drives the register's ctrl/data inputs and reads its q output, paced by a bit-rate tick. It exposes valid/ready handshakes on the parallel side.

---
 rtl/shift_seq_ctrl_pkg.sv | 22 ++
 rtl/shift_seq_ctrl_if.sv | 23 ++
 rtl/shift_seq_ctrl_bit_counter.sv | 29 ++
 rtl/shift_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared encodings for the shift register sequencing controller
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SR_HOLD = 2'd0;
  localparam logic [1:0] SR_SHR  = 2'd1;
  localparam logic [1:0] SR_SHL  = 2'd2;
  localparam logic [1:0] SR_LOAD = 2'd3;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  function automatic logic [1:0] shift_code(input bit lsb_first);
    return lsb_first ? SR_SHR : SR_SHL;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - parallel-side TX/RX valid/ready bus of the sequencing controller
interface shift_seq_ctrl_if #(
  parameter int N = 8
);

  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/shift_seq_ctrl_bit_counter.sv
// rtl/shift_seq_ctrl_bit_counter.sv - serial bit counter with clear/enable and last-bit flag
module shift_seq_ctrl_bit_counter #(
  parameter int LIMIT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  // clear together with enable counts the current bit, so the counter lands on 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_en ? W'(1) : '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - drives a universal shift register as a serializer or deserializer
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_mode,
  input  logic                  i_bit_tick,
  input  logic                  i_ser_in,
  input  logic [N-1:0]          i_sr_q,
  shift_seq_ctrl_if.slave       bus,
  output logic                  o_ser_out,
  output logic                  o_ser_out_valid,
  output logic                  o_rx_overrun,
  output logic                  o_busy,
  output logic [1:0]            o_sr_ctrl,
  output logic [N-1:0]          o_sr_data
);

  localparam logic [1:0] SH = shift_code(LSB_FIRST);

  state_t       r_state;
  logic         r_mode;

  logic         w_tap;
  logic         w_tx_load;
  logic         w_rx_start;
  logic         w_shift_tick;
  logic         w_last;
  logic         w_tx_ready;
  logic         w_ser_out;
  logic         w_ser_valid;
  logic         w_rx_valid;
  logic         w_overrun;
  logic [N-1:0] w_rx_data;
  logic [1:0]   w_sr_ctrl;
  logic [N-1:0] w_sr_data;

  assign w_tap        = LSB_FIRST ? i_sr_q[0] : i_sr_q[N-1];
  assign w_tx_load    = (r_state == IDLE) && (i_mode == MODE_TX) && bus.tx_valid;
  assign w_rx_start   = (r_state == IDLE) && (i_mode == MODE_RX) && i_bit_tick;
  assign w_shift_tick = (r_state == SHIFT) && i_bit_tick;

  shift_seq_ctrl_bit_counter #(
    .LIMIT (N)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_clear (w_tx_load | w_rx_start),
    .i_en    (w_rx_start | w_shift_tick),
    .o_last  (w_last)
  );

  // r_mode freezes the direction for the whole word; i_mode only matters in IDLE
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_mode  <= MODE_TX;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tx_load) begin
            r_state <= SHIFT;
            r_mode  <= MODE_TX;
          end else if (w_rx_start) begin
            r_state <= SHIFT;
            r_mode  <= MODE_RX;
          end
        end
        SHIFT: begin
          if (i_bit_tick && w_last) begin
            r_state <= (r_mode == MODE_RX) ? DONE : IDLE;
          end
        end
        DONE: begin
          if (bus.rx_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_sr_ctrl   = SR_HOLD;
    w_sr_data   = '0;
    w_tx_ready  = 1'b0;
    w_ser_out   = 1'b0;
    w_ser_valid = 1'b0;
    w_rx_valid  = 1'b0;
    w_rx_data   = '0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mode == MODE_TX) begin
          w_tx_ready = 1'b1;
          if (bus.tx_valid) begin
            w_sr_ctrl = SR_LOAD;
            w_sr_data = bus.tx_data;
          end
        end else if (i_bit_tick) begin
          w_sr_ctrl = SH;
          w_sr_data = {N{i_ser_in}};
        end
      end
      SHIFT: begin
        if (r_mode == MODE_TX) begin
          w_ser_valid = 1'b1;
          w_ser_out   = w_tap;
          if (i_bit_tick) begin
            w_sr_ctrl = SH;
          end
        end else if (i_bit_tick) begin
          w_sr_ctrl = SH;
          w_sr_data = {N{i_ser_in}};
        end
      end
      DONE: begin
        w_rx_valid = 1'b1;
        w_rx_data  = i_sr_q;
        w_overrun  = i_bit_tick;
      end
      default: ;
    endcase
  end

  // every output is held at zero for as long as reset is asserted
  assign bus.tx_ready    = w_tx_ready & i_reset_n;
  assign bus.rx_valid    = w_rx_valid & i_reset_n;
  assign bus.rx_data     = w_rx_data & {N{i_reset_n}};
  assign o_ser_out       = w_ser_out & i_reset_n;
  assign o_ser_out_valid = w_ser_valid & i_reset_n;
  assign o_rx_overrun    = w_overrun & i_reset_n;
  assign o_busy          = (r_state != IDLE) & i_reset_n;
  assign o_sr_ctrl       = w_sr_ctrl & {2{i_reset_n}};
  assign o_sr_data       = w_sr_data & {N{i_reset_n}};

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - randomized self-checking bench covering both bit orders
module tb_shift_seq_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         reset_n;
  logic         mode;
  logic         bit_tick;
  logic         ser_in;
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         rx_ready;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.N(N)) bus_l ();
  shift_seq_ctrl_if #(.N(N)) bus_m ();

  assign bus_l.tx_data  = tx_data;
  assign bus_l.tx_valid = tx_valid;
  assign bus_l.rx_ready = rx_ready;
  assign bus_m.tx_data  = tx_data;
  assign bus_m.tx_valid = tx_valid;
  assign bus_m.rx_ready = rx_ready;

  logic         so_l, sov_l, ovr_l, busy_l;
  logic [1:0]   ctl_l;
  logic [N-1:0] sd_l, q_l;
  logic         so_m, sov_m, ovr_m, busy_m;
  logic [1:0]   ctl_m;
  logic [N-1:0] sd_m, q_m;

  shift_seq_ctrl #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_reset_n(reset_n), .i_mode(mode), .i_bit_tick(bit_tick),
    .i_ser_in(ser_in), .i_sr_q(q_l), .bus(bus_l), .o_ser_out(so_l),
    .o_ser_out_valid(sov_l), .o_rx_overrun(ovr_l), .o_busy(busy_l),
    .o_sr_ctrl(ctl_l), .o_sr_data(sd_l)
  );

  shift_seq_ctrl #(.N(N), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_reset_n(reset_n), .i_mode(mode), .i_bit_tick(bit_tick),
    .i_ser_in(ser_in), .i_sr_q(q_m), .bus(bus_m), .o_ser_out(so_m),
    .o_ser_out_valid(sov_m), .o_rx_overrun(ovr_m), .o_busy(busy_m),
    .o_sr_ctrl(ctl_m), .o_sr_data(sd_m)
  );

  // universal shift register the controller drives
  function automatic logic [N-1:0] sr_next(input logic [N-1:0] q, input logic [1:0] c,
                                           input logic [N-1:0] d);
    case (c)
      2'd1:    return {d[N-1], q[N-1:1]};
      2'd2:    return {q[N-2:0], d[0]};
      2'd3:    return d;
      default: return q;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_l <= '0;
      q_m <= '0;
    end else begin
      q_l <= sr_next(q_l, ctl_l, sd_l);
      q_m <= sr_next(q_m, ctl_m, sd_m);
    end
  end

  typedef struct packed {
    logic         tx_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         rx_valid;
    logic         overrun;
    logic         busy;
    logic [1:0]   ctl;
    logic [N-1:0] sd;
    logic [N-1:0] rxd;
  } obs_t;

  function automatic obs_t peek(input int g);
    if (g == 0)
      return '{bus_l.tx_ready, so_l, sov_l, bus_l.rx_valid, ovr_l, busy_l, ctl_l, sd_l, bus_l.rx_data};
    return '{bus_m.tx_ready, so_m, sov_m, bus_m.rx_valid, ovr_m, busy_m, ctl_m, sd_m, bus_m.rx_data};
  endfunction

  // instance 0 sends LSB first with right shifts, instance 1 MSB first with left shifts
  function automatic logic [1:0] exp_sh(input int g);
    return (g == 0) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic exp_tx_bit(input int g, input logic [N-1:0] w, input int i);
    return (g == 0) ? w[i] : w[N-1-i];
  endfunction

  function automatic logic [N-1:0] exp_rx_word(input int g, input logic [N-1:0] seq);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[(g == 0) ? k : N-1-k] = seq[k];
    return r;
  endfunction

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_word(input logic [N-1:0] w, input bit collide, input int gap_max,
                         input int stop, input int toggle_at);
    obs_t o;
    mode = 1'b0; tx_data = w; tx_valid = 1'b1; bit_tick = collide;
    settle();
    for (int g = 0; g < 2; g++) begin
      o = peek(g);
      chk("tx_load", g, {o.tx_ready, o.ctl, o.sd}, {1'b1, 2'd3, w});
    end
    adv();
    tx_valid = 1'b0; bit_tick = 1'b0; tx_data = N'($urandom);
    for (int i = 0; i < stop; i++) begin
      if (i == toggle_at) mode = 1'b1;
      repeat ($urandom_range(0, gap_max)) begin
        settle();
        for (int g = 0; g < 2; g++) begin
          o = peek(g);
          chk("tx_gap", g, {o.ser_valid, o.ser_out, o.ctl}, {1'b1, exp_tx_bit(g, w, i), 2'd0});
        end
        adv();
      end
      bit_tick = 1'b1;
      settle();
      for (int g = 0; g < 2; g++) begin
        o = peek(g);
        chk("tx_bit", g, {o.ser_valid, o.ser_out}, {1'b1, exp_tx_bit(g, w, i)});
        chk("tx_shift", g, {o.busy, o.tx_ready, o.ctl, o.sd}, {1'b1, 1'b0, exp_sh(g), N'(0)});
      end
      adv();
      bit_tick = 1'b0;
    end
    if (stop == N) begin
      settle();
      for (int g = 0; g < 2; g++) begin
        o = peek(g);
        chk("tx_end", g, {o.busy, o.ser_valid, o.tx_ready}, {1'b0, 1'b0, ~mode});
      end
    end
  endtask

  task automatic rx_word(input logic [N-1:0] seq, input int gap_max, input int extra,
                         input bit tick_on_accept);
    obs_t o;
    mode = 1'b1;
    for (int k = 0; k < N; k++) begin
      repeat (((k == 0) ? 1 : 0) + $urandom_range(0, gap_max)) begin
        bit_tick = 1'b0; ser_in = ~seq[k];
        settle();
        for (int g = 0; g < 2; g++) begin
          o = peek(g);
          chk("rx_gap", g, {o.busy, o.ctl, o.rx_valid}, {k != 0, 2'd0, 1'b0});
        end
        adv();
      end
      ser_in = seq[k]; bit_tick = 1'b1;
      settle();
      for (int g = 0; g < 2; g++) begin
        o = peek(g);
        chk("rx_shift", g, {o.ctl, o.sd}, {exp_sh(g), {N{seq[k]}}});
      end
      adv();
      bit_tick = 1'b0;
    end
    for (int e = 0; e <= extra; e++) begin
      if (e > 0) begin
        bit_tick = 1'b1; ser_in = 1'($urandom);
        settle();
        for (int g = 0; g < 2; g++) begin
          o = peek(g);
          chk("rx_overrun", g, {o.rx_valid, o.overrun, o.ctl, o.rxd},
              {1'b1, 1'b1, 2'd0, exp_rx_word(g, seq)});
        end
        adv();
        bit_tick = 1'b0;
      end
      settle();
      for (int g = 0; g < 2; g++) begin
        o = peek(g);
        chk("rx_hold", g, {o.rx_valid, o.overrun, o.busy, o.ctl, o.rxd},
            {1'b1, 1'b0, 1'b1, 2'd0, exp_rx_word(g, seq)});
      end
      adv();
    end
    rx_ready = 1'b1; bit_tick = tick_on_accept;
    settle();
    for (int g = 0; g < 2; g++) begin
      o = peek(g);
      chk("rx_accept", g, {o.rx_valid, o.overrun, o.rxd}, {1'b1, tick_on_accept, exp_rx_word(g, seq)});
    end
    adv();
    rx_ready = 1'b0; bit_tick = 1'b0;
    settle();
    for (int g = 0; g < 2; g++) begin
      o = peek(g);
      chk("rx_idle", g, {o.busy, o.rx_valid, o.overrun}, 3'b000);
    end
  endtask

  initial begin
    obs_t o;
    reset_n = 1'b0; mode = 1'b0; bit_tick = 1'b0; ser_in = 1'b0;
    tx_data = 8'hFF; tx_valid = 1'b1; rx_ready = 1'b0;
    settle();
    for (int g = 0; g < 2; g++) chk("reset_outputs", g, peek(g), 32'd0);
    adv();
    adv();
    reset_n = 1'b1; tx_valid = 1'b0;
    settle();
    for (int g = 0; g < 2; g++) begin
      o = peek(g);
      chk("reset_idle", g, {o.busy, o.tx_ready, o.ser_valid, o.rx_valid}, 4'b0100);
    end

    tx_word(8'hA5, 1'b0, 0, N, -1);
    tx_word(N'($urandom), 1'b0, 2, N, -1);
    tx_word(8'h5A, 1'b1, 1, N, -1);
    rx_word(8'h53, 0, 2, 1'b0);
    tx_word(N'($urandom), 1'b0, 1, N, 3);
    rx_word(N'($urandom), 1, 0, 1'b1);

    tx_word(8'h96, 1'b0, 1, 3, -1);
    reset_n = 1'b0; tx_valid = 1'b1;
    settle();
    for (int g = 0; g < 2; g++) chk("reset_mid_tx", g, peek(g), 32'd0);
    adv();
    reset_n = 1'b1; tx_valid = 1'b0; mode = 1'b0;
    settle();
    for (int g = 0; g < 2; g++) begin
      o = peek(g);
      chk("post_reset", g, {o.busy, o.tx_ready, o.ser_valid, o.rx_valid, o.overrun}, 5'b01000);
    end
    tx_word(8'h3C, 1'b0, 1, N, -1);

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 0)
        tx_word(N'($urandom), 1'($urandom), int'($urandom_range(0, 3)), N,
                int'($urandom_range(0, N + 3)));
      else
        rx_word(N'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
